// File: rtl/ercm_mul_arbiter.sv
// Two-requester round-robin front end for a shared approximate 8x8 multiplier.
// Operands and a per-requester mask are held for WAIT_CYC cycles, then the product is returned.
module ercm_mul_arbiter #(
  parameter int IN_W     = 8,
  parameter int MASK_W   = 7,
  parameter int WAIT_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic [IN_W-1:0]     req0_a,
  input  logic [IN_W-1:0]     req0_b,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [IN_W-1:0]     req1_a,
  input  logic [IN_W-1:0]     req1_b,
  output logic                req1_ready,
  output logic                rsp0_valid,
  output logic                rsp1_valid,
  output logic [2*IN_W-1:0]   rsp_p,
  input  logic                cfg_we,
  input  logic                cfg_sel,
  input  logic [MASK_W-1:0]   cfg_mask,
  output logic [IN_W-1:0]     mul_a,
  output logic [IN_W-1:0]     mul_b,
  output logic [MASK_W-1:0]   mul_mask,
  input  logic [2*IN_W-1:0]   mul_p,
  output logic                busy
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [MASK_W-1:0]   mask0_q, mask0_d;
  logic [MASK_W-1:0]   mask1_q, mask1_d;
  logic [IN_W-1:0]     mul_a_q, mul_a_d;
  logic [IN_W-1:0]     mul_b_q, mul_b_d;
  logic [MASK_W-1:0]   mul_mask_q, mul_mask_d;
  logic [2*IN_W-1:0]   rsp_p_q, rsp_p_d;
  logic                rsp0_valid_q, rsp0_valid_d;
  logic                rsp1_valid_q, rsp1_valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_grant_q, last_grant_d;
  logic                id_q, id_d;

  logic                grant_valid;
  logic                grant_id;
  logic                can_accept;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign grant_valid = req0_valid | req1_valid;
  assign can_accept  = !rst && (state_q == IDLE);
  assign req0_ready  = can_accept && grant_valid && !grant_id;
  assign req1_ready  = can_accept && grant_valid && grant_id;

  // Mask writes land at the edge; an accept in the same cycle still sees the old value.
  always_comb begin
    mask0_d = mask0_q;
    mask1_d = mask1_q;
    if (cfg_we && !cfg_sel) mask0_d = cfg_mask;
    if (cfg_we && cfg_sel)  mask1_d = cfg_mask;
  end

  always_comb begin
    state_d      = state_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_mask_d   = mul_mask_q;
    rsp_p_d      = rsp_p_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          mul_a_d      = grant_id ? req1_a : req0_a;
          mul_b_d      = grant_id ? req1_b : req0_b;
          mul_mask_d   = grant_id ? mask1_q : mask0_q;
          cnt_d        = CNT_LOAD;
          last_grant_d = grant_id;
          id_d         = grant_id;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_p_d      = mul_p;
          rsp0_valid_d = !id_q;
          rsp1_valid_d = id_q;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mask0_q      <= '0;
      mask1_q      <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_mask_q   <= '0;
      rsp_p_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask0_q      <= mask0_d;
      mask1_q      <= mask1_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_mask_q   <= mul_mask_d;
      rsp_p_q      <= rsp_p_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
    end
  end

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_mask   = mul_mask_q;
  assign rsp_p      = rsp_p_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign busy       = (state_q == WAIT);

endmodule

// File: tb/tb_ercm_mul_arbiter.sv
// Directed bench for ercm_mul_arbiter: stimulus pushes expected responses, a monitor pops and checks them.
// The multiplier stand-in clears product bits selected by the mask so mask routing shows up in rsp_p.
module tb_ercm_mul_arbiter;

  localparam int IN_W     = 8;
  localparam int MASK_W   = 7;
  localparam int WAIT_CYC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req1_valid;
  logic [IN_W-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic              req0_ready, req1_ready;
  logic              rsp0_valid, rsp1_valid;
  logic [2*IN_W-1:0] rsp_p;
  logic              cfg_we, cfg_sel;
  logic [MASK_W-1:0] cfg_mask;
  logic [IN_W-1:0]   mul_a, mul_b;
  logic [MASK_W-1:0] mul_mask;
  logic [2*IN_W-1:0] mul_p;
  logic              busy;

  ercm_mul_arbiter #(.IN_W(IN_W), .MASK_W(MASK_W), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_p(rsp_p),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_mask(cfg_mask),
    .mul_a(mul_a), .mul_b(mul_b), .mul_mask(mul_mask), .mul_p(mul_p),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign mul_p = (16'(mul_a) * 16'(mul_b)) & ~{9'b0, mul_mask};

  typedef struct {
    bit          id;
    logic [15:0] p;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic push(input bit id, input logic [15:0] p);
    exp_t e;
    e.id  = id;
    e.p   = p;
    e.due = cyc + WAIT_CYC + 1;
    exp_q.push_back(e);
  endtask

  // Monitor: one check line per response pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp0_valid && rsp1_valid) chk("rsp_both_valid", 32'd1, 32'd0);
      if (rsp0_valid || rsp1_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", {31'd0, rsp1_valid}, {31'd0, e.id});
          chk("rsp_p", {16'd0, rsp_p}, {16'd0, e.p});
          chk("rsp_cycle", cyc, e.due);
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        chk("rsp_missing", 32'd0, 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 8'd200; req0_b = 8'd100;
    req1_a = 8'd255; req1_b = 8'd255;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_mask = '0;

    // Reset held with both valids high
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
      chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      chk("rst_rsp_p", {16'd0, rsp_p}, 32'd0);
      chk("rst_mul", {9'd0, mul_a, mul_b, mul_mask}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // First cycle after release: requester 0 wins the tie (single op 200*100)
    @(negedge clk);
    chk("first_ready0", {31'd0, req0_ready}, 32'd1);
    chk("first_ready1", {31'd0, req1_ready}, 32'd0);
    push(1'b0, 16'd20000);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    for (int k = 1; k <= WAIT_CYC; k++) begin
      if (k > 1) @(negedge clk); else @(negedge clk);
      chk("op0_mul_a", {24'd0, mul_a}, 32'd200);
      chk("op0_mul_b", {24'd0, mul_b}, 32'd100);
      chk("op0_mul_mask", {25'd0, mul_mask}, 32'd0);
      chk("op0_busy", {31'd0, busy}, 32'd1);
      chk("op0_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    end

    // Response cycle is IDLE and accepts the waiting full-scale request 1
    @(negedge clk);
    chk("full_ready1", {31'd0, req1_ready}, 32'd1);
    chk("full_busy", {31'd0, busy}, 32'd0);
    chk("idle_hold_mul_a", {24'd0, mul_a}, 32'd200);
    push(1'b1, 16'd65025);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (WAIT_CYC) @(negedge clk);
    @(negedge clk);
    repeat (5) @(negedge clk);
    chk("rsp_p_hold", {16'd0, rsp_p}, 32'd65025);

    // Round robin with both valids held for four operations
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 8'd1; req0_b = 8'd2;
    req1_a = 8'd3; req1_b = 8'd4;
    for (int j = 0; j < 4 * (WAIT_CYC + 1); j++) begin
      bit acc;
      bit eid;
      acc = (j % (WAIT_CYC + 1)) == 0;
      eid = ((j / (WAIT_CYC + 1)) % 2) == 1;
      @(negedge clk);
      chk("rr_busy", {31'd0, busy}, {31'd0, !acc});
      chk("rr_ready0", {31'd0, req0_ready}, {31'd0, acc && !eid});
      chk("rr_ready1", {31'd0, req1_ready}, {31'd0, acc && eid});
      if (acc) push(eid, eid ? 16'd12 : 16'd2);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Mask 1 written one cycle before a request-1 accept
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_mask = 7'h55;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    req1_valid = 1'b1; req1_a = 8'd3; req1_b = 8'd5;
    @(negedge clk);
    chk("m1_ready1", {31'd0, req1_ready}, 32'd1);
    push(1'b1, 16'd10);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    for (int k = 0; k < WAIT_CYC; k++) begin
      @(negedge clk);
      chk("m1_mul_mask", {25'd0, mul_mask}, 32'h55);
    end

    // Mask 0 written in the same cycle as a request-0 accept: old mask used
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 8'd10; req0_b = 8'd10;
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_mask = 7'h2A;
    @(negedge clk);
    chk("m0a_ready0", {31'd0, req0_ready}, 32'd1);
    push(1'b0, 16'd100);
    @(posedge clk); #1;
    req0_valid = 1'b0; cfg_we = 1'b0;
    for (int k = 0; k < WAIT_CYC; k++) begin
      @(negedge clk);
      chk("m0a_mul_mask", {25'd0, mul_mask}, 32'd0);
    end
    @(posedge clk); #1;
    req0_valid = 1'b1;
    @(negedge clk);
    chk("m0b_ready0", {31'd0, req0_ready}, 32'd1);
    push(1'b0, 16'd68);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    for (int k = 0; k < WAIT_CYC; k++) begin
      @(negedge clk);
      chk("m0b_mul_mask", {25'd0, mul_mask}, 32'h2A);
    end

    // Reset two cycles into WAIT abandons the operation
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 8'd7; req0_b = 8'd9;
    @(negedge clk);
    chk("ab_ready0", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("ab_rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 8'd6; req0_b = 8'd7;
    req1_a = 8'd5; req1_b = 8'd3;
    @(negedge clk);
    chk("ab_mul_cleared", {9'd0, mul_a, mul_b, mul_mask}, 32'd0);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_rsp_p", {16'd0, rsp_p}, 32'd0);
    chk("ab_ready0", {31'd0, req0_ready}, 32'd1);
    chk("ab_ready1", {31'd0, req1_ready}, 32'd0);
    push(1'b0, 16'd42);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    for (int k = 0; k < WAIT_CYC; k++) begin
      @(negedge clk);
      chk("ab_mask0_cleared", {25'd0, mul_mask}, 32'd0);
    end
    @(negedge clk);
    chk("ab_next_ready1", {31'd0, req1_ready}, 32'd1);
    push(1'b1, 16'd15);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    for (int k = 0; k < WAIT_CYC; k++) begin
      @(negedge clk);
      chk("ab_mask1_cleared", {25'd0, mul_mask}, 32'd0);
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ercm_mul_arbiter.md
Name: ercm_mul_arbiter

Overview:
- Shares one approximate 8x8 multiplier (ERCM-style: operands plus 7-bit mask, 16-bit product) between two requesters.
- Round-robin arbitration between the requesters.
- Holds a separate accuracy mask per requester, configured through a small write port.
- Drives the multiplier's operands and mask stable for a fixed settle window, then samples the product and returns it to the winning requester.

Parameters:
- IN_W, 8, operand width per input.
- MASK_W, 7, multiplier mask width.
- WAIT_CYC, 4, cycles operands are held stable before the product is sampled; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_a  in  IN_W  requester 0 operand A.
- req0_b  in  IN_W  requester 0 operand B.
- req0_ready  out  1  requester 0 accepted this cycle (combinational).
- req1_valid, req1_a, req1_b, req1_ready  same as requester 0, for requester 1.
- rsp0_valid  out  1  one-cycle pulse, product for requester 0.
- rsp1_valid  out  1  one-cycle pulse, product for requester 1.
- rsp_p  out  2*IN_W  product; qualified by rsp0_valid/rsp1_valid.
- cfg_we  in  1  mask write strobe.
- cfg_sel  in  1  selects mask register 0 or 1.
- cfg_mask  in  MASK_W  mask write data.
- mul_a  out  IN_W  to multiplier dat_in_a.
- mul_b  out  IN_W  to multiplier dat_in_b.
- mul_mask  out  MASK_W  to multiplier mask.
- mul_p  in  2*IN_W  from multiplier dat_o.
- busy  out  1  high while not IDLE.

Behaviour:
- Reset values (synchronous): state=IDLE; mask0=mask1=0 (exact mode); mul_a=mul_b=mul_mask=0; rsp_p=0; rsp0_valid=rsp1_valid=0; wait counter=0; last_grant=1, so requester 0 wins the first tie; busy=0.

FSM states: IDLE, WAIT.

IDLE:
- Grant: if exactly one reqN_valid, grant N. If both, grant the requester that is not last_grant.
- reqN_ready = (state==IDLE) && grant==N, combinational.
- Ready is never asserted outside IDLE or while rst is high.
- Accept happens in the cycle T where valid&&ready. On the clock edge ending T:
  - mul_a/mul_b take the granted operands.
  - mul_mask takes maskN.
  - counter loads WAIT_CYC-1.
  - last_grant takes N.
  - the granted requester ID is latched.
  - state moves to WAIT.

WAIT:
- mul_* held constant.
- Each cycle: if counter==0, sample mul_p into rsp_p, set rspN_valid for the latched ID, and go to IDLE on that edge. Otherwise decrement the counter.
- WAIT lasts exactly WAIT_CYC cycles (T+1 .. T+WAIT_CYC).

Response:
- rspN_valid is high in cycle T+WAIT_CYC+1 only.
- There is no backpressure; the requester must capture rsp_p on the pulse.
- rsp_p holds its value until the next response.

Throughput:
- IDLE in the response cycle may accept a new request.
- One operation per WAIT_CYC+1 cycles.

Operand and mask handling:
- reqN_a/b need to be valid only in the accept cycle.
- mul_* retain the last operation's values while IDLE; no toggling between operations.

Mask configuration:
- cfg_we writes mask[cfg_sel] at the clock edge; allowed in any state.
- An operation in flight is unaffected, because mul_mask was latched at accept.
- A write in the same cycle as an accept of the same requester: the accepted operation uses the old mask.

Other rules:
- Width: rsp_p = mul_p, unmodified; the block performs no arithmetic on the product.
- busy = (state==WAIT).
- Reset mid-operation: the operation is abandoned. No rspN_valid is emitted, masks clear to 0, and last_grant returns to 1.
- A request withdrawn before ready is simply dropped; there is no queueing beyond a single in-flight operation.

Test Plan:
- Reset: hold rst 2 cycles with both valids high. Required: no ready, all outputs 0, busy=0. First cycle after release, req0_ready=1 and req1_ready=0.
- Single op: WAIT_CYC=4, exact multiplier model, mask0=0, req0 a=200 b=100 accepted at T. Required: mul_a=200, mul_b=100, mul_mask=0 for T+1..T+4; rsp0_valid only at T+5; rsp_p=20000; rsp1_valid stays 0.
- Full-scale operands: req1 a=255 b=255. Required: rsp1_valid pulse with rsp_p=65025; rsp_p still 65025 five cycles later.
- Round robin: both valids held continuously for 4 operations. Required: grant order 0,1,0,1; each accept exactly WAIT_CYC+1 cycles after the previous one; busy low only in the accept cycles.
- Mask config: write cfg_sel=1 mask=7'h55 one cycle before a req1 accept. Required: mul_mask=7'h55 during WAIT. Then, in a req0 accept cycle, write cfg_sel=0 mask=7'h2A. Required: that op uses mul_mask=0; the next req0 op uses 7'h2A.
- Reset in WAIT: accept at T, assert rst at T+2. Required: no rsp pulse, mul_* and masks return to 0, and the next simultaneous request grants requester 0.
